// File: rtl/view_scroller.sv
// Camera controller for the vertical-scrolling play field: smooth follow, fall
// detection, peak-height score and spawn-row requests over a req/ack handshake.
module view_scroller #(
  parameter int Y_WIDTH       = 32,
  parameter int SCREEN_HEIGHT = 700,
  parameter int SCROLL_LINE   = 350,
  parameter int SCROLL_STEP   = 4,
  parameter int SPAWN_SPACING = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [Y_WIDTH-1:0] doodle_y,
  input  logic               doodle_valid,
  output logic [Y_WIDTH-1:0] camera_y,
  output logic [Y_WIDTH-1:0] scroll_delta,
  output logic               scrolling,
  output logic [Y_WIDTH-1:0] max_y,
  output logic               fell_off,
  output logic               spawn_req,
  output logic [Y_WIDTH-1:0] spawn_y,
  input  logic               spawn_ack
);

  typedef logic [Y_WIDTH-1:0] y_t;
  typedef logic [Y_WIDTH:0]   ext_t;
  typedef enum logic [1:0] {IDLE, SCROLL, OVER} state_t;

  localparam ext_t MAX_CAM = ext_t'({Y_WIDTH{1'b1}}) - ext_t'(SCREEN_HEIGHT);

  state_t r_state, w_state_nxt;
  y_t     r_camera, r_target, r_delta, r_max, r_acc, r_spawn_y;
  logic   r_fell, r_req;

  y_t     w_camera_nxt, w_target_nxt, w_delta_nxt, w_max_nxt, w_acc_nxt;
  y_t     w_step, w_gap;
  logic   w_fell_nxt, w_fall, w_raise;
  ext_t   w_diff, w_cand, w_clamp, w_acc_sum;
  y_t     w_acc_sat;

  // Extended-width arithmetic keeps the height comparisons free of wrap.
  assign w_fall  = doodle_valid && (doodle_y < r_camera);
  assign w_diff  = ext_t'(doodle_y) - ext_t'(r_camera);
  assign w_cand  = ext_t'(doodle_y) - ext_t'(SCROLL_LINE);
  assign w_clamp = (w_cand > MAX_CAM) ? MAX_CAM : w_cand;

  always_comb begin
    w_state_nxt  = r_state;
    w_camera_nxt = r_camera;
    w_target_nxt = r_target;
    w_delta_nxt  = r_delta;
    w_max_nxt    = r_max;
    w_fell_nxt   = r_fell;
    w_gap        = '0;
    w_step       = '0;
    case (r_state)
      IDLE, SCROLL: begin
        if (frame_tick) begin
          if (w_fall) begin
            w_state_nxt = OVER;
            w_fell_nxt  = 1'b1;
            w_delta_nxt = '0;
          end else begin
            if (doodle_valid && (w_diff > ext_t'(SCROLL_LINE)) &&
                (w_clamp > ext_t'(r_target)))
              w_target_nxt = y_t'(w_clamp);
            // target never trails the camera, so this gap cannot underflow
            w_gap        = w_target_nxt - r_camera;
            w_step       = (w_gap > y_t'(SCROLL_STEP)) ? y_t'(SCROLL_STEP) : w_gap;
            w_camera_nxt = r_camera + w_step;
            w_delta_nxt  = w_step;
            if (doodle_valid && (doodle_y > r_max))
              w_max_nxt = doodle_y;
            w_state_nxt  = (w_target_nxt > w_camera_nxt) ? SCROLL : IDLE;
          end
        end
      end
      OVER:    w_delta_nxt = '0;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requests are raised from the registered camera/accumulator, one cycle after
  // the tick that crossed the spacing; a drop always leaves one low cycle.
  assign w_raise   = !r_req && (r_state != OVER) && (r_acc >= y_t'(SPAWN_SPACING));
  assign w_acc_sum = ext_t'(r_acc) + ext_t'(w_step);
  assign w_acc_sat = w_acc_sum[Y_WIDTH] ? {Y_WIDTH{1'b1}} : w_acc_sum[Y_WIDTH-1:0];
  assign w_acc_nxt = w_acc_sat - (w_raise ? y_t'(SPAWN_SPACING) : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_camera  <= '0;
      r_target  <= '0;
      r_delta   <= '0;
      r_max     <= '0;
      r_acc     <= '0;
      r_fell    <= 1'b0;
      r_req     <= 1'b0;
      r_spawn_y <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_camera <= w_camera_nxt;
      r_target <= w_target_nxt;
      r_delta  <= w_delta_nxt;
      r_max    <= w_max_nxt;
      r_fell   <= w_fell_nxt;
      r_acc    <= w_acc_nxt;
      if (r_req) begin
        if (spawn_ack) r_req <= 1'b0;
      end else if (w_raise) begin
        r_req     <= 1'b1;
        r_spawn_y <= r_camera + y_t'(SCREEN_HEIGHT);
      end
    end
  end

  assign camera_y     = r_camera;
  assign scroll_delta = r_delta;
  assign scrolling    = (r_state == SCROLL);
  assign max_y        = r_max;
  assign fell_off     = r_fell;
  assign spawn_req    = r_req;
  assign spawn_y      = r_spawn_y;

endmodule

// File: tb/tb_view_scroller.sv
// Randomized + directed bench for view_scroller: a reference model pushes the
// expected outputs per cycle; a monitor pops and compares after each edge.
module tb_view_scroller;
  localparam int YW = 10, SH = 700, SL = 350, SS = 4, SP = 8;
  localparam int ONES = (1 << YW) - 1;
  localparam int MAXC = ONES - SH;

  logic          clk, reset, frame_tick, doodle_valid, spawn_ack;
  logic [YW-1:0] doodle_y, camera_y, scroll_delta, max_y, spawn_y;
  logic          scrolling, fell_off, spawn_req;

  view_scroller #(.Y_WIDTH(YW), .SCREEN_HEIGHT(SH), .SCROLL_LINE(SL),
                  .SCROLL_STEP(SS), .SPAWN_SPACING(SP)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .doodle_y(doodle_y),
    .doodle_valid(doodle_valid), .camera_y(camera_y), .scroll_delta(scroll_delta),
    .scrolling(scrolling), .max_y(max_y), .fell_off(fell_off),
    .spawn_req(spawn_req), .spawn_y(spawn_y), .spawn_ack(spawn_ack));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cam, dlt, mx, sy; bit scr, fell, req; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // reference state: plain integers, never wrap
  int m_cam, m_tgt, m_dlt, m_max, m_acc, m_sy;
  bit m_fell, m_req;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  function automatic void chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, req, $time);
    end
  endfunction

  function automatic void model_step();
    int y, add, old_cam;
    bit raise;
    exp_t e;
    y = int'(doodle_y);
    if (reset) begin
      m_cam = 0; m_tgt = 0; m_dlt = 0; m_max = 0; m_acc = 0; m_sy = 0;
      m_fell = 0; m_req = 0;
    end else begin
      old_cam = m_cam;
      raise = !m_req && !m_fell && (m_acc >= SP);
      add = 0;
      if (frame_tick && !m_fell) begin
        if (doodle_valid && y < m_cam) begin
          m_fell = 1; m_dlt = 0;
        end else begin
          if (doodle_valid && (y - m_cam > SL)) m_tgt = imax(m_tgt, imin(y - SL, MAXC));
          add = imin(SS, m_tgt - m_cam);
          m_cam += add; m_dlt = add;
          if (doodle_valid && y > m_max) m_max = y;
        end
      end
      m_acc = imin(m_acc + add, ONES) - (raise ? SP : 0);
      if (m_req) begin
        if (spawn_ack) m_req = 0;
      end else if (raise) begin
        m_req = 1; m_sy = old_cam + SH;
      end
    end
    e.cam = m_cam; e.dlt = m_dlt; e.mx = m_max; e.sy = m_sy;
    e.scr = !m_fell && (m_tgt > m_cam); e.fell = m_fell; e.req = m_req;
    q.push_back(e);
  endfunction

  // monitor: compare every cycle the driver has queued an expectation for
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("camera_y", int'(camera_y), e.cam);
      chk("scroll_delta", int'(scroll_delta), e.dlt);
      chk("max_y", int'(max_y), e.mx);
      chk("scrolling", int'(scrolling), int'(e.scr));
      chk("fell_off", int'(fell_off), int'(e.fell));
      chk("spawn_req", int'(spawn_req), int'(e.req));
      if (e.req) chk("spawn_y", int'(spawn_y), e.sy);
    end
  end

  // drive one cycle starting at a negedge; returns at the following negedge
  task automatic cyc(input bit rst, input bit tk, input bit v, input int y, input bit ack);
    int yc;
    yc = imin(imax(y, 0), ONES);
    reset = rst; frame_tick = tk; doodle_valid = v; spawn_ack = ack;
    doodle_y = yc[YW-1:0];
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int y;
    bit seen;
    reset = 1; frame_tick = 0; doodle_valid = 0; doodle_y = '0; spawn_ack = 0;
    @(negedge clk);

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, ONES)), 1'($urandom));
    chk("rst_cam", int'(camera_y), 0);
    chk("rst_req", int'(spawn_req), 0);
    chk("rst_spy", int'(spawn_y), 0);

    // smooth scroll
    cyc(0, 1, 1, 360, 0);
    chk("ss_cam1", int'(camera_y), 4); chk("ss_dlt1", int'(scroll_delta), 4);
    chk("ss_scr1", int'(scrolling), 1);
    cyc(0, 0, 0, 0, 0);
    chk("ss_hold_dlt", int'(scroll_delta), 4);
    cyc(0, 1, 0, 0, 0);
    chk("ss_cam2", int'(camera_y), 8);
    cyc(0, 1, 0, 0, 0);
    chk("ss_cam3", int'(camera_y), 10); chk("ss_dlt3", int'(scroll_delta), 2);
    chk("ss_scr3", int'(scrolling), 0);
    cyc(0, 1, 0, 0, 0);
    chk("ss_dlt4", int'(scroll_delta), 0); chk("ss_max", int'(max_y), 360);

    // fall
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 450, 1);
    for (int i = 0; i < 26; i++) cyc(0, 1, 0, 0, 1);
    chk("fall_cam_pre", int'(camera_y), 100);
    cyc(0, 1, 1, 99, 0);
    chk("fall_flag", int'(fell_off), 1); chk("fall_cam", int'(camera_y), 100);
    chk("fall_dlt", int'(scroll_delta), 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 900, i[0]);
    chk("over_cam", int'(camera_y), 100); chk("over_max", int'(max_y), 450);
    chk("over_fell", int'(fell_off), 1);

    // spawn handshake
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 366, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("sp_cam8", int'(camera_y), 8);
    chk("sp_not_yet", int'(spawn_req), 0);
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc(0, 0, 0, 0, 0);
      seen = spawn_req;
    end
    chk("sp_req1_seen", int'(seen), 1);
    chk("sp_y1", int'(spawn_y), 708);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("sp_hold_req", int'(spawn_req), 1); chk("sp_hold_y", int'(spawn_y), 708);
    end
    chk("sp_cam16", int'(camera_y), 16);
    cyc(0, 0, 0, 0, 1);
    chk("sp_drop", int'(spawn_req), 0);
    cyc(0, 0, 0, 0, 0);
    chk("sp_req2", int'(spawn_req), 1); chk("sp_y2", int'(spawn_y), 716);
    cyc(0, 0, 0, 0, 1);

    // saturation at the top of the Y range
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, ONES, 1);
    for (int i = 0; i < 90; i++) cyc(0, 1, i[1], ONES, 1);
    chk("sat_cam", int'(camera_y), MAXC); chk("sat_scr", int'(scrolling), 0);
    chk("sat_dlt", int'(scroll_delta), 0);

    // reset mid-scroll with a pending request
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 500, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(0, 1, 0, 0, 0);
      seen = spawn_req;
    end
    chk("mid_req_seen", int'(seen), 1); chk("mid_scr", int'(scrolling), 1);
    cyc(1, 1, 1, 900, 1);
    chk("mid_rst_cam", int'(camera_y), 0); chk("mid_rst_req", int'(spawn_req), 0);
    cyc(0, 1, 1, 200, 0);
    chk("mid_noscroll", int'(camera_y), 0); chk("mid_nodlt", int'(scroll_delta), 0);

    // randomized traffic
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (m_cam > 0 && $urandom_range(0, 149) == 0) y = m_cam - int'($urandom_range(1, 20));
      else y = m_cam + int'($urandom_range(0, 700));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0, y, $urandom_range(0, 2) == 0);
    end
    cyc(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/view_scroller.md
# view_scroller

Clocked, parametrised camera controller for the vertical-scrolling play field. It tracks the world-space camera (bottom edge of the visible screen) against the doodle's height and advances the camera smoothly, at most `SCROLL_STEP` pixels per frame. It also detects the doodle falling below the screen, records the peak height reached, and requests new platform rows from the block spawner through a req/ack handshake. It sits between the physics/doodle block and the renderer/spawner, and replaces the combinational view logic.

## Interface
Parameters:
- `Y_WIDTH`, 32: width of all world-space Y values; world Y is unsigned and grows upward.
- `SCREEN_HEIGHT`, 700: visible height in pixels.
- `SCROLL_LINE`, 350: screen-relative height above which the camera must follow.
- `SCROLL_STEP`, 4: maximum camera advance per frame tick; must be ≥1.
- `SPAWN_SPACING`, 70: camera travel per spawn request; must be ≥1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per frame; all scroll work happens on it.
- `doodle_y`, in, `Y_WIDTH`: doodle world Y.
- `doodle_valid`, in, 1: `doodle_y` is meaningful this tick.
- `camera_y`, out, `Y_WIDTH`: world Y of the screen bottom.
- `scroll_delta`, out, `Y_WIDTH`: pixels advanced on the most recent tick.
- `scrolling`, out, 1: the camera target is above `camera_y`.
- `max_y`, out, `Y_WIDTH`: highest valid `doodle_y` seen (score basis).
- `fell_off`, out, 1: sticky game-over flag.
- `spawn_req`, out, 1: a new row is needed at `spawn_y`.
- `spawn_y`, out, `Y_WIDTH`: world Y of the new row; stable while `spawn_req` is high.
- `spawn_ack`, in, 1: the spawner accepts the request.

## Operation
- States:
  - IDLE: target equals camera.
  - SCROLL: target is above camera.
  - OVER: doodle fell off the screen.
- Constant `MAX_CAM = 2^Y_WIDTH − 1 − SCREEN_HEIGHT`. Internal `target_y` register.
- Processing on `frame_tick` in IDLE/SCROLL, in this order:
  1. Fall check, only if `doodle_valid`. If `doodle_y < camera_y`, go to OVER and set `fell_off`=1. On that tick the camera does not move, `scroll_delta`=0, and `max_y` is not updated. Fall wins over any simultaneous scroll.
  2. Target update, only if `doodle_valid`. If `doodle_y − camera_y > SCROLL_LINE`, set `target_y = max(target_y, min(doodle_y − SCROLL_LINE, MAX_CAM))`. The target never decreases. Compute the subtraction in `Y_WIDTH+1` bits; no wrap.
  3. Advance. Compute `step = min(SCROLL_STEP, target_y − camera_y)` using the updated target. Then `camera_y += step`, `scroll_delta = step`, and `spawn_acc += step`.
  4. Score. If `doodle_valid` and `doodle_y > max_y`, set `max_y = doodle_y`.
  5. State. Go to SCROLL if `target_y > camera_y` after the advance, otherwise IDLE. `scrolling` mirrors SCROLL.
- When `doodle_valid`=0 on a tick, steps 1, 2 and 4 are skipped. The camera still advances toward the existing target.
- Spawn handshake:
  - Raise `spawn_req`, when none is pending, once `spawn_acc ≥ SPAWN_SPACING`. At that point load `spawn_y = camera_y + SCREEN_HEIGHT` and subtract `SPAWN_SPACING` from `spawn_acc`.
  - `spawn_req` and `spawn_y` hold until `spawn_ack`=1 is sampled. `spawn_req` drops the next cycle.
  - If another spacing is still owed, the next request rises one cycle after that drop, so there is at least one low cycle between requests.
  - `spawn_ack` while `spawn_req`=0 is ignored.
  - `spawn_acc` saturates at all-ones.
- OVER:
  - `frame_tick` is ignored.
  - `camera_y`, `max_y` and `spawn_y` are frozen, and `scroll_delta` is forced to 0.
  - A pending `spawn_req` still completes on ack; no new request is raised.
  - Only `reset` exits OVER.

## Timing
- Reset (synchronous): state IDLE. `camera_y`, `target_y`, `scroll_delta`, `max_y` and `spawn_acc` = 0. `spawn_y` = 0. `scrolling`, `fell_off` and `spawn_req` = 0. Reset overrides all other inputs, including mid-scroll and mid-handshake; a pending request is dropped without ack.
- Latency: the effects of a tick are visible on outputs in the cycle after `frame_tick` is sampled.
- `scroll_delta` holds its value until the next processed tick.
- A spawn request rises at the earliest one cycle after the camera update that crossed the spacing, i.e. two cycles after the tick.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs → all outputs 0 the cycle after release, state IDLE.
- Smooth scroll (defaults):
  - Stimulus: tick with `doodle_y`=360, then 3 more ticks with `doodle_valid`=0.
  - Required: target 10; `camera_y` 4, 8, 10 after ticks 1–3 with `scroll_delta` 4, 4, 2; `scrolling` 1, 1, 0; tick 4 gives `scroll_delta` 0; `max_y`=360.
- Fall:
  - Stimulus: drive `camera_y` to 100, then tick with `doodle_y`=99 and `SCROLL_LINE` crossed elsewhere.
  - Required: `fell_off`=1 next cycle, `camera_y` stays 100, later ticks with `doodle_y`=900 change nothing until reset.
- Spawn handshake:
  - Stimulus: `SPAWN_SPACING`=8, `doodle_y`=366, ack withheld 5 cycles, then ack pulsed.
  - Required: camera reaches 8 on tick 2; `spawn_req`=1 with `spawn_y`=708, held stable through the 5 unacked cycles; ack → drop next cycle; second request (`spawn_y`=716 or later) only after camera reaches 16 and at least one low cycle.
- Saturation (`Y_WIDTH`=10):
  - Stimulus: tick with `doodle_y`=1023.
  - Required: target clamps to `MAX_CAM`=323; camera never exceeds 323; no wrap in any register.
- Reset mid-operation: assert `reset` while in SCROLL with `spawn_req`=1 → next cycle all outputs 0, `spawn_req`=0, and a following tick with `doodle_y`=200 produces no scroll.
